// File: rtl/video_pkg.sv
// Shared types and the signature fold for the raster video frame checker.
package video_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef logic [9:0] pos_t;

  typedef enum logic {
    IDLE,
    CAPTURE
  } vfc_state_e;

  // One fold step: rotate the running signature left by one, then mix in the pixel.
  function automatic logic [31:0] sig_step(input logic [31:0] sig, input logic [31:0] pix);
    return {sig[30:0], sig[31]} ^ pix;
  endfunction

endpackage

// File: rtl/frame_signature_acc.sv
// Running rotate-xor signature over the active pixels of the frame being captured.
module frame_signature_acc
  import video_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        init,
  input  logic        step,
  input  logic [31:0] pix,
  output logic [31:0] signature
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, whatever the block order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      signature <= '0;
    end else if (init) begin
      signature <= pix;
    end else if (step) begin
      signature <= sig_step(signature, pix);
    end
  end

endmodule

// File: rtl/video_frame_checker.sv
// Raster sequence checker: follows the expected pixel position, folds each complete
// frame into a signature and hands one result per frame out on a valid/ready port.
module video_frame_checker
  import video_pkg::*;
#(
  parameter int COLOR_BITS = 24,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    display_enable_i,
  input  logic [9:0]              hpos_i,
  input  logic [9:0]              vpos_i,
  input  logic [COLOR_BITS/3-1:0] red_i,
  input  logic [COLOR_BITS/3-1:0] green_i,
  input  logic [COLOR_BITS/3-1:0] blue_i,
  input  logic                    result_ready_i,
  input  logic                    clear_errors_i,
  output logic                    result_valid_o,
  output logic [31:0]             frame_signature_o,
  output logic [15:0]             frame_count_o,
  output logic                    err_sequence_o,
  output logic                    err_overrun_o
);

  localparam pos_t H_LAST  = pos_t'(H_ACTIVE - 1);
  localparam pos_t V_LAST  = pos_t'(V_ACTIVE - 1);
  localparam pos_t POS_ONE = pos_t'(1);

  vfc_state_e  state;
  pos_t        exp_h;
  pos_t        exp_v;
  logic [31:0] pix;
  logic [31:0] sig;
  logic        pos_match;
  logic        at_origin;
  logic        start;
  logic        step;
  logic        mismatch;
  logic        last;
  logic        transfer;
  logic        overrun;

  assign pix       = 32'({red_i, green_i, blue_i});
  assign pos_match = (hpos_i == exp_h) && (vpos_i == exp_v);
  assign at_origin = (hpos_i == '0) && (vpos_i == '0);
  assign step      = display_enable_i && (state == CAPTURE) && pos_match;
  assign mismatch  = display_enable_i && (state == CAPTURE) && !pos_match;
  // A mismatching (0,0) restarts the frame in the same cycle as the error.
  assign start     = display_enable_i && at_origin && ((state == IDLE) || mismatch);
  assign last      = step && (exp_h == H_LAST) && (exp_v == V_LAST);
  assign transfer  = result_valid_o && result_ready_i;
  assign overrun   = last && result_valid_o && !result_ready_i;

  frame_signature_acc u_acc (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .init      (start),
    .step      (step),
    .pix       (pix),
    .signature (sig)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state             <= IDLE;
      exp_h             <= '0;
      exp_v             <= '0;
      result_valid_o    <= 1'b0;
      frame_signature_o <= '0;
      frame_count_o     <= '0;
      err_sequence_o    <= 1'b0;
      err_overrun_o     <= 1'b0;
    end else begin
      if (start) begin
        state <= CAPTURE;
        exp_h <= POS_ONE;
        exp_v <= '0;
      end else if (last || mismatch) begin
        state <= IDLE;
      end else if (step) begin
        if (exp_h == H_LAST) begin
          exp_h <= '0;
          exp_v <= exp_v + POS_ONE;
        end else begin
          exp_h <= exp_h + POS_ONE;
        end
      end

      // The result register takes the fold including the final pixel, so it is
      // presented one cycle after that pixel is sampled.
      if (last) begin
        frame_count_o <= frame_count_o + 16'd1;
        if (!result_valid_o || result_ready_i) begin
          result_valid_o    <= 1'b1;
          frame_signature_o <= sig_step(sig, pix);
        end
      end else if (transfer) begin
        result_valid_o <= 1'b0;
      end

      err_sequence_o <= mismatch | (err_sequence_o & ~clear_errors_i);
      err_overrun_o  <= overrun  | (err_overrun_o  & ~clear_errors_i);
    end
  end

endmodule

// File: tb/tb_video_frame_checker.sv
// Self-checking bench for video_frame_checker on a 4x2 raster with a frame-level reference model.
module tb_video_frame_checker;

  localparam int H = 4;
  localparam int V = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [9:0]  hpos = '0;
  logic [9:0]  vpos = '0;
  logic [7:0]  red = '0;
  logic [7:0]  green = '0;
  logic [7:0]  blue = '0;
  logic        ready = 1'b0;
  logic        clear = 1'b0;
  logic        valid;
  logic [31:0] sig;
  logic [15:0] cnt;
  logic        eseq;
  logic        eovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_frame_checker #(.COLOR_BITS(24), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .display_enable_i  (en),
    .hpos_i            (hpos),
    .vpos_i            (vpos),
    .red_i             (red),
    .green_i           (green),
    .blue_i            (blue),
    .result_ready_i    (ready),
    .clear_errors_i    (clear),
    .result_valid_o    (valid),
    .frame_signature_o (sig),
    .frame_count_o     (cnt),
    .err_sequence_o    (eseq),
    .err_overrun_o     (eovr)
  );

  // Reference model: a frame is the list of in-order pixels; its signature is
  // the xor of each pixel rotated left by the number of pixels that follow it.
  logic        m_valid = 1'b0;
  logic [31:0] m_sig = '0;
  logic [15:0] m_cnt = '0;
  logic        m_seq = 1'b0;
  logic        m_ovr = 1'b0;
  bit          m_active = 1'b0;
  int          m_next = 0;
  logic [31:0] m_pix[$];

  function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
    int r = k % 32;
    if (r == 0) return x;
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [31:0] fold_frame();
    logic [31:0] acc = '0;
    int n = m_pix.size();
    for (int i = 0; i < n; i++) acc ^= rotl(m_pix[i], n - 1 - i);
    return acc;
  endfunction

  task automatic model_update();
    logic [31:0] p;
    logic [31:0] new_sig;
    bit done, seq_set, ovr_set, xfer;
    if (reset) begin
      m_valid = 0; m_sig = '0; m_cnt = '0; m_seq = 0; m_ovr = 0;
      m_active = 0; m_next = 0; m_pix.delete();
      return;
    end
    p = {8'h00, red, green, blue};
    done = 0; seq_set = 0; ovr_set = 0; new_sig = '0;
    xfer = m_valid && ready;
    if (en) begin
      if (m_active && int'(hpos) == m_next % H && int'(vpos) == m_next / H) begin
        m_pix.push_back(p);
        m_next++;
        if (m_next == H * V) begin
          done = 1;
          new_sig = fold_frame();
          m_active = 0;
        end
      end else begin
        if (m_active) begin
          seq_set = 1;
          m_active = 0;
        end
        if (hpos == 0 && vpos == 0) begin
          m_active = 1;
          m_pix.delete();
          m_pix.push_back(p);
          m_next = 1;
        end
      end
    end
    if (done) begin
      m_cnt = m_cnt + 16'd1;
      if (!m_valid || ready) begin
        m_sig = new_sig;
        m_valid = 1;
      end else begin
        ovr_set = 1;
      end
    end else if (xfer) begin
      m_valid = 0;
    end
    m_seq = seq_set ? 1'b1 : (clear ? 1'b0 : m_seq);
    m_ovr = ovr_set ? 1'b1 : (clear ? 1'b0 : m_ovr);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send_pixel(input int h, input int v, input logic [23:0] rgb);
    en = 1'b1;
    hpos = 10'(h);
    vpos = 10'(v);
    {red, green, blue} = rgb;
    step();
  endtask

  task automatic blank_cycle();
    en = 1'b0;
    hpos = 10'($urandom);
    vpos = 10'($urandom);
    {red, green, blue} = 24'($urandom);
    step();
  endtask

  task automatic send_frame(input logic [23:0] rgb, input bit rand_rgb, input bit blanking);
    for (int i = 0; i < H * V; i++) begin
      if (blanking) repeat ($urandom_range(0, 3)) blank_cycle();
      send_pixel(i % H, i / H, rand_rgb ? 24'($urandom) : rgb);
    end
    en = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    en = 1'b0;
    clear = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++;
    if ({valid, sig, cnt, eseq, eovr} !== 51'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b sig=%h cnt=%0d seq=%0b ovr=%0b, want all 0",
               valid, sig, cnt, eseq, eovr);
    end
  endtask

  task automatic test_basic_frame();
    ready = 1'b1;
    for (int i = 0; i < H * V; i++) begin
      send_pixel(i % H, i / H, 24'h000001);
      if (i == H * V - 2) begin
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_early_valid: got %0b want 0", valid);
        end
      end
    end
    en = 1'b0;
    checks++;
    if (valid !== 1'b1 || sig !== 32'h000000FF || cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_result: got valid=%0b sig=%h cnt=%0d, want 1 000000ff 1", valid, sig, cnt);
    end
    blank_cycle();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_transfer: got valid=%0b want 0", valid);
    end
  endtask

  task automatic test_blanking();
    ready = 1'b1;
    send_frame(24'h000001, 1'b0, 1'b1);
    checks++;
    if (valid !== 1'b1 || sig !== 32'h000000FF || cnt !== 16'd2) begin
      errors++;
      $display("FAIL blank_result: got valid=%0b sig=%h cnt=%0d, want 1 000000ff 2", valid, sig, cnt);
    end
    blank_cycle();
  endtask

  task automatic test_sequence_error();
    ready = 1'b1;
    for (int i = 0; i < H * V; i++) begin
      if (i == 2) send_pixel(3, 0, 24'h000001);
      else send_pixel(i % H, i / H, 24'h000001);
    end
    en = 1'b0;
    blank_cycle();
    checks++;
    if (eseq !== 1'b1 || valid !== 1'b0 || cnt !== 16'd2) begin
      errors++;
      $display("FAIL seq_detect: got seq=%0b valid=%0b cnt=%0d, want 1 0 2", eseq, valid, cnt);
    end
    send_frame(24'h0, 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b1 || sig !== m_sig || eseq !== 1'b1) begin
      errors++;
      $display("FAIL seq_recover: got valid=%0b sig=%h seq=%0b, want 1 %h 1", valid, sig, eseq, m_sig);
    end
    clear = 1'b1;
    blank_cycle();
    clear = 1'b0;
    checks++;
    if (eseq !== 1'b0) begin
      errors++;
      $display("FAIL seq_clear: got %0b want 0", eseq);
    end
    // Error and clear in the same cycle: the error must survive.
    send_pixel(0, 0, 24'h000001);
    clear = 1'b1;
    send_pixel(2, 0, 24'h000001);
    clear = 1'b0;
    en = 1'b0;
    checks++;
    if (eseq !== 1'b1) begin
      errors++;
      $display("FAIL seq_set_wins: got %0b want 1", eseq);
    end
    clear = 1'b1;
    blank_cycle();
    clear = 1'b0;
  endtask

  task automatic test_overrun();
    logic [31:0] first_sig;
    pulse_reset();
    ready = 1'b0;
    send_frame(24'h0, 1'b1, 1'b1);
    first_sig = m_sig;
    send_frame(24'h0, 1'b1, 1'b1);
    blank_cycle();
    checks++;
    if (valid !== 1'b1 || sig !== first_sig || eovr !== 1'b1 || cnt !== 16'd2) begin
      errors++;
      $display("FAIL overrun_hold: got valid=%0b sig=%h ovr=%0b cnt=%0d, want 1 %h 1 2",
               valid, sig, eovr, cnt, first_sig);
    end
    ready = 1'b1;
    blank_cycle();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_transfer: got valid=%0b want 0", valid);
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    ready = 1'b0;
    send_frame(24'h000001, 1'b0, 1'b0);
    blank_cycle();
    for (int i = 0; i < H * V; i++) begin
      ready = (i == H * V - 1);
      send_pixel(i % H, i / H, 24'h000003);
    end
    ready = 1'b0;
    en = 1'b0;
    checks++;
    if (valid !== 1'b1 || sig !== 32'h00000101 || eovr !== 1'b0 || cnt !== 16'd2) begin
      errors++;
      $display("FAIL b2b_load: got valid=%0b sig=%h ovr=%0b cnt=%0d, want 1 00000101 0 2",
               valid, sig, eovr, cnt);
    end
  endtask

  task automatic test_mid_frame_reset();
    pulse_reset();
    ready = 1'b0;
    send_frame(24'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_pixel(i % H, i / H, 24'($urandom));
    reset = 1'b1;
    step();
    reset = 1'b0;
    en = 1'b0;
    checks++;
    if ({valid, sig, cnt, eseq, eovr} !== 51'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%0b sig=%h cnt=%0d seq=%0b ovr=%0b, want all 0",
               valid, sig, cnt, eseq, eovr);
    end
    ready = 1'b1;
    send_frame(24'h000001, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b1 || sig !== 32'h000000FF || cnt !== 16'd1) begin
      errors++;
      $display("FAIL midreset_frame: got valid=%0b sig=%h cnt=%0d, want 1 000000ff 1", valid, sig, cnt);
    end
  endtask

  task automatic test_random_stream();
    int cur = 0;
    int r;
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 99);
      ready = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 24) == 0);
      if (r < 65) begin
        send_pixel(cur % H, cur / H, 24'($urandom));
        cur = (cur + 1) % (H * V);
      end else if (r < 72) begin
        send_pixel($urandom_range(0, H), $urandom_range(0, V), 24'($urandom));
        if (hpos == 0 && vpos == 0) cur = 1;
      end else begin
        blank_cycle();
      end
      checks++;
      if ({valid, sig, cnt, eseq, eovr} !== {m_valid, m_sig, m_cnt, m_seq, m_ovr}) begin
        errors++;
        $display("FAIL random_c%0d: got valid=%0b sig=%h cnt=%0d seq=%0b ovr=%0b, want %0b %h %0d %0b %0b",
                 c, valid, sig, cnt, eseq, eovr, m_valid, m_sig, m_cnt, m_seq, m_ovr);
      end
    end
    clear = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_blanking();
    test_sequence_error();
    test_overrun();
    test_back_to_back();
    test_mid_frame_reset();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
